// File: rtl/seq_detector_moore_1011.sv
// Moore detector for the serial pattern 1-0-1-1, overlapping occurrences included.
// One bit is consumed per rising clock edge; detector_out is high for exactly one
// clock period while the FSM holds the "pattern complete" state.
module seq_detector_moore_1011 (
    input  logic clock,
    input  logic reset,
    input  logic sequence_in,
    output logic detector_out
);

    // Binary encoding: codes 5..7 are unused and recover to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,   // no useful prefix
        S_1    = 3'd1,   // seen "1"
        S_10   = 3'd2,   // seen "10"
        S_101  = 3'd3,   // seen "101"
        S_1011 = 3'd4    // seen "1011"
    } state_t;

    state_t state;

    // Longest useful prefix after appending bit_in to the history held in cur.
    function automatic state_t next_state(input state_t cur, input logic bit_in);
        state_t nxt;
        nxt = S_IDLE;
        case (cur)
            S_IDLE: nxt = bit_in ? S_1    : S_IDLE;
            S_1:    nxt = bit_in ? S_1    : S_10;
            S_10:   nxt = bit_in ? S_101  : S_IDLE;
            S_101:  nxt = bit_in ? S_1011 : S_10;
            // Trailing "1" of a completed pattern is reused as the start of the next.
            S_1011: nxt = bit_in ? S_1    : S_10;
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    // State register with the flag registered alongside it; the flag is computed
    // from the incoming state so it always equals (state == S_1011).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            detector_out <= 1'b0;
        end else begin
            state        <= next_state(state, sequence_in);
            detector_out <= (next_state(state, sequence_in) == S_1011);
        end
    end

endmodule

// File: tb/tb_seq_detector_moore_1011.sv
// Directed-vector bench for seq_detector_moore_1011: each task drives a short bit
// stream and compares detector_out and the FSM state against hand-derived values.
`timescale 1ns/1ps
module tb_seq_detector_moore_1011;

    logic clock;
    logic reset;
    logic sequence_in;
    logic detector_out;
    logic [2:0] st;

    int vectors;
    int miscompares;

    seq_detector_moore_1011 dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .detector_out (detector_out)
    );

    assign st = dut.state;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one bit at the falling edge, then move to 1 ns after the sampling edge.
    task automatic drive_bit(input logic b);
        @(negedge clock);
        sequence_in = b;
        @(posedge clock);
        #1;
    endtask

    // Hold reset for three clocks, release at a falling edge.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        sequence_in = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        sequence_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            vectors++;
            if (detector_out !== 1'b0 || st !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: out=%b state=%0d, want out=0 state=0", i, detector_out, st);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'b0);
            vectors++;
            if (detector_out !== 1'b0 || st !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_zeros[%0d]: out=%b state=%0d, want out=0 state=0", i, detector_out, st);
            end
        end
    endtask

    task automatic test_basic();
        logic       bits [6] = '{1, 0, 1, 1, 0, 0};
        logic [2:0] exp_st [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_bit(bits[i]);
            vectors++;
            if (detector_out !== (exp_st[i] == 3'd4) || st !== exp_st[i]) begin
                miscompares++;
                $display("FAIL basic[%0d]: out=%b state=%0d, want out=%b state=%0d",
                         i, detector_out, st, (exp_st[i] == 3'd4), exp_st[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic       bits [7] = '{1, 0, 1, 1, 0, 1, 1};
        logic [2:0] exp_st [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive_bit(bits[i]);
            if (detector_out === 1'b1) pulses++;
            vectors++;
            if (detector_out !== (exp_st[i] == 3'd4) || st !== exp_st[i]) begin
                miscompares++;
                $display("FAIL overlap[%0d]: out=%b state=%0d, want out=%b state=%0d",
                         i, detector_out, st, (exp_st[i] == 3'd4), exp_st[i]);
            end
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL overlap_pulses: got %0d, want 2", pulses);
        end
    endtask

    task automatic test_near_miss();
        logic       bits [12] = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1};
        logic [2:0] exp_st [12] = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2,
                                    3'd3, 3'd2, 3'd0, 3'd1, 3'd1, 3'd1};
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive_bit(bits[i]);
            vectors++;
            if (detector_out !== 1'b0 || st !== exp_st[i]) begin
                miscompares++;
                $display("FAIL near_miss[%0d]: out=%b state=%0d, want out=0 state=%0d",
                         i, detector_out, st, exp_st[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        vectors++;
        if (st !== 3'd3) begin
            miscompares++;
            $display("FAIL async_pre: state=%0d, want 3", st);
        end
        // Assert reset between edges (posedge+3ns), check before the next edge.
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (st !== 3'd0 || detector_out !== 1'b0) begin
            miscompares++;
            $display("FAIL async_mid: out=%b state=%0d, want out=0 state=0", detector_out, st);
        end
        @(negedge clock);
        reset = 1'b0;
        drive_bit(1'b1);
        vectors++;
        if (st !== 3'd1 || detector_out !== 1'b0) begin
            miscompares++;
            $display("FAIL async_after: out=%b state=%0d, want out=0 state=1", detector_out, st);
        end
        // Reset while the flag is high must clear it without a clock edge.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        vectors++;
        if (detector_out !== 1'b1) begin
            miscompares++;
            $display("FAIL async_flag_pre: out=%b, want 1", detector_out);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (detector_out !== 1'b0 || st !== 3'd0) begin
            miscompares++;
            $display("FAIL async_flag_clear: out=%b state=%0d, want out=0 state=0", detector_out, st);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic bits [8]    = '{1, 0, 1, 1, 1, 0, 1, 1};
        logic exp_out [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive_bit(bits[i]);
            vectors++;
            if (detector_out !== exp_out[i]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: out=%b, want %b", i, detector_out, exp_out[i]);
            end
        end
    endtask

    task automatic test_waveform();
        logic       bits [10] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        logic [2:0] exp_st [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2,
                                    3'd0, 3'd1, 3'd1, 3'd2, 3'd0};
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive_bit(bits[i]);
            if (detector_out === 1'b1) pulses++;
            vectors++;
            if (detector_out !== (exp_st[i] == 3'd4) || st !== exp_st[i]) begin
                miscompares++;
                $display("FAIL waveform[%0d]: out=%b state=%0d, want out=%b state=%0d",
                         i, detector_out, st, (exp_st[i] == 3'd4), exp_st[i]);
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL waveform_pulses: got %0d, want 1", pulses);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        sequence_in = 1'b0;
        #1;
        vectors++;
        if (detector_out !== 1'b0 || st !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_initial: out=%b state=%0d, want out=0 state=0", detector_out, st);
        end
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_async_reset();
        test_back_to_back();
        test_waveform();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detector_moore_1011.md
Name: seq_detector_moore_1011

Overview:
Moore finite-state machine that watches a serial bit stream and flags every occurrence of the pattern 1-0-1-1. Overlapping occurrences are detected. The block sits on a serial data path and samples one bit per clock. Its single flag output depends only on the current state, never directly on the input.

Parameters:
None. The pattern 1011 and the state encoding are fixed.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset; forces the FSM to its idle state
sequence_in  input  1  serial data bit, sampled on each rising edge of clock
detector_out  output  1  high while the FSM is in the "pattern complete" state

Behaviour:
- One clock. Reset is asynchronous and active-high (port reset). Asserting reset immediately forces state=S_IDLE and detector_out=0, independent of clock. The FSM leaves S_IDLE only on the first rising edge after reset deasserts.
- State register: 3-bit binary encoding.
  - S_IDLE=0: no useful prefix.
  - S_1=1: seen "1".
  - S_10=2: seen "10".
  - S_101=3: seen "101".
  - S_1011=4: seen "1011".
- Transitions are evaluated on rising clock, using sequence_in sampled at that edge. Read each row as "state: input 0 -> next; input 1 -> next".
  - S_IDLE: 0 -> S_IDLE; 1 -> S_1.
  - S_1: 0 -> S_10; 1 -> S_1.
  - S_10: 0 -> S_IDLE; 1 -> S_101.
  - S_101: 0 -> S_10; 1 -> S_1011.
  - S_1011: 0 -> S_10 (overlap on trailing "1"); 1 -> S_1.
- Unused codes 5..7: next state is S_IDLE unconditionally, and detector_out=0 while in them.
- detector_out is decoded from the state register only: 1 iff state==S_1011.
  - It asserts for exactly one clock period, starting at the edge that samples the 4th pattern bit.
  - This gives 0 cycles of latency after that edge and 1 cycle after the last bit is presented.
- Back-to-back overlapped detections are supported, e.g. 1011011 gives two pulses.
- Non-overlapped restarts such as 1011 then 1011 give two pulses, 4 cycles apart.
- Reset mid-pattern discards all progress. Reset while detector_out=1 clears it immediately.
- No enable input: every rising edge consumes one bit.

Test Plan:
- Reset: hold reset=1 for 3 clocks with sequence_in=0, then release. Required: detector_out=0 throughout, and it stays 0 while feeding zeros.
- Basic detect: after reset, feed bits 1,0,1,1,0,0 on consecutive edges. Required: detector_out=1 only in the period after the 4th edge, with state S_1011 then S_10 then S_IDLE.
- Overlap: feed 1,0,1,1,0,1,1. Required: detector_out pulses after the 4th and 7th bits, two single-cycle pulses.
- Near misses: feed 1,1,0,0,1,0,1,0,0,1,1,1. Required: detector_out never asserts.
  - Also check states: "11" stays S_1; "100" returns to S_IDLE; "1010" goes to S_10.
- Async reset mid-pattern: feed 1,0,1, assert reset between edges, release, then feed 1. Required:
  - state goes to S_IDLE without a clock edge;
  - detector_out stays 0;
  - after the 1, state is S_1, not S_1011.
- Stimulus matching a reference waveform: reset high for 30 ns, then bits sampled 1,0,1,1,0,0,1,1,0,0 with a 10 ns period. Required: exactly one detector_out pulse, at the 4th sampled bit.
